// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR random-number generator:
//   - fsm_e        : draw-port FSM states (IDLE / DRAW / HOLD)
//   - TAPS_Wn      : maximal-length Galois tap masks for 5, 8, 16 and 32 bits
//   - lfsr_step()  : one Galois step, computed at LFSR_MAX_W bits; callers
//                    zero-extend their state and truncate the result, so any
//                    state width up to LFSR_MAX_W is supported.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_DRAW = 2'd1,
    FSM_HOLD = 2'd2
  } fsm_e;

  // Right-shifting Galois masks (bit n-1 set = x^n term).
  localparam logic [4:0]  TAPS_W5  = 5'h14;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // The shifted-out bit decides whether the feedback mask is applied.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] shifted;
    shifted = state >> 1;
    if (state[0]) begin
      return shifted ^ taps;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/lfsr_random_gen_if.sv
// -----------------------------------------------------------------------------
// lfsr_random_gen_if
// Control / draw-port bundle of lfsr_random_gen.
//   master (consumer side): drives en, seed_load, seed_in, req, out_ready;
//                           observes req_ready, out_valid, out_value, state.
//   slave  (generator side): the opposite directions.
// -----------------------------------------------------------------------------
interface lfsr_random_gen_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 4
);
  logic             en;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             req;
  logic             req_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_value;
  logic             out_ready;
  logic [WIDTH-1:0] state;

  modport master (
    output en, seed_load, seed_in, req, out_ready,
    input  req_ready, out_valid, out_value, state
  );

  modport slave (
    input  en, seed_load, seed_in, req, out_ready,
    output req_ready, out_valid, out_value, state
  );
endinterface

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// Galois LFSR state register with seed load and lock-up recovery.
//   clk, rst  : clock, asynchronous active-high reset (state <- SEED)
//   step_en   : advance one step this edge
//   load_en   : load load_val (zero is replaced by SEED); wins over stepping
//   load_val  : seed value
//   state     : registered LFSR state
// WIDTH must not exceed lfsr_pkg::LFSR_MAX_W.
// -----------------------------------------------------------------------------
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step_val;

  // Next-state selection: load, then lock-up recovery, then step, else hold.
  always_comb begin
    step_val = WIDTH'(lfsr_step(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS)));
    state_d  = state_q;
    if (load_en) begin
      if (load_val == {WIDTH{1'b0}}) begin
        state_d = SEED;
      end else begin
        state_d = load_val;
      end
    end else if (state_q == {WIDTH{1'b0}}) begin
      // All-zero is a fixed point of the Galois step; escape it unconditionally.
      state_d = SEED;
    end else if (step_en) begin
      state_d = step_val;
    end else begin
      state_d = state_q;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_random_gen.sv
// -----------------------------------------------------------------------------
// lfsr_random_gen
// Draw port on top of lfsr_core: each request returns a value in 0..RANGE-1,
// rejection-sampled from the low OUT_W bits of the LFSR, optionally never
// repeating the previous draw, with a deterministic fallback after MAX_TRIES.
//   clk, rst : clock, asynchronous active-high reset (aborts any draw)
//   bus      : lfsr_random_gen_if.slave (en, seed_load, seed_in, req,
//              req_ready, out_valid, out_value, out_ready, state)
// -----------------------------------------------------------------------------
module lfsr_random_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W16,
  parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
  parameter int               OUT_W     = 4,
  parameter int               RANGE     = 9,
  parameter int               NO_REPEAT = 1,
  parameter int               MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_random_gen_if.slave bus
);

  // One extra bit so MAX_TRIES == 1 still yields a legal counter width.
  localparam int                 TRIES_W  = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]     RANGE_X  = (OUT_W + 1)'(RANGE);

  logic [WIDTH-1:0]   core_state;
  logic               step_en;

  fsm_e               fsm_q, fsm_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0]   last_q, last_d;
  logic               has_last_q, has_last_d;
  logic [OUT_W-1:0]   out_value_q, out_value_d;
  logic               out_valid_q, out_valid_d;
  logic               req_ready_q, req_ready_d;

  logic [OUT_W-1:0]   cand;
  logic               cand_ok;
  logic [OUT_W:0]     last_inc;
  logic [OUT_W-1:0]   wrap_value;

  assign step_en = bus.en | (fsm_q == FSM_DRAW);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .step_en  (step_en),
    .load_en  (bus.seed_load),
    .load_val (bus.seed_in),
    .state    (core_state)
  );

  // Candidate qualification and fallback value (compare-and-wrap, no divider).
  always_comb begin
    cand     = core_state[OUT_W-1:0];
    cand_ok  = ({1'b0, cand} < RANGE_X);
    if ((NO_REPEAT != 0) && has_last_q && (cand == last_q)) begin
      cand_ok = 1'b0;
    end else begin
      cand_ok = cand_ok;
    end
    last_inc = {1'b0, last_q} + {{OUT_W{1'b0}}, 1'b1};
    if (!has_last_q) begin
      wrap_value = {OUT_W{1'b0}};
    end else if (last_inc >= RANGE_X) begin
      wrap_value = {OUT_W{1'b0}};
    end else begin
      wrap_value = last_inc[OUT_W-1:0];
    end
  end

  // Draw FSM next-state and registered-output computation.
  always_comb begin
    fsm_d       = fsm_q;
    tries_d     = tries_q;
    last_d      = last_q;
    has_last_d  = has_last_q;
    out_value_d = out_value_q;
    case (fsm_q)
      FSM_IDLE: begin
        if (bus.req) begin
          fsm_d   = FSM_DRAW;
          tries_d = {TRIES_W{1'b0}};
        end else begin
          fsm_d = FSM_IDLE;
        end
      end
      FSM_DRAW: begin
        if (bus.seed_load) begin
          // The load owns this edge; the loaded state is judged next cycle.
          fsm_d = FSM_DRAW;
        end else if (cand_ok) begin
          out_value_d = cand;
          last_d      = cand;
          has_last_d  = 1'b1;
          fsm_d       = FSM_HOLD;
        end else if (tries_q == LAST_TRY) begin
          out_value_d = wrap_value;
          last_d      = wrap_value;
          has_last_d  = 1'b1;
          fsm_d       = FSM_HOLD;
        end else begin
          tries_d = tries_q + TRIES_W'(1);
        end
      end
      FSM_HOLD: begin
        if (bus.out_ready) begin
          fsm_d = FSM_IDLE;
        end else begin
          fsm_d = FSM_HOLD;
        end
      end
      default: begin
        fsm_d = FSM_IDLE;
      end
    endcase
    req_ready_d = (fsm_d == FSM_IDLE);
    out_valid_d = (fsm_d == FSM_HOLD);
  end

  // FSM, draw bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= FSM_IDLE;
      tries_q     <= {TRIES_W{1'b0}};
      last_q      <= {OUT_W{1'b0}};
      has_last_q  <= 1'b0;
      out_value_q <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      tries_q     <= tries_d;
      last_q      <= last_d;
      has_last_q  <= has_last_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.state     = core_state;

endmodule
